lighthouse_sweep_timer: RTL and testbench

Measures lighthouse sweep-hit timestamps for four photodiode sensors (F, C, L, R) relative to the preceding sync flash. Produces the four 16-bit words and the latch strobe consumed directly by the SPI readout memory stage. One capture frame runs per sync pulse. Results are held stable between strobes.

---
 rtl/lighthouse_pkg.sv | 25 ++
 rtl/sensor_cond.sv | 68 ++++++
 rtl/lighthouse_sweep_timer.sv | 220 ++++++++++++++++++++++
 tb/tb_lighthouse_sweep_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lighthouse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lighthouse_pkg
// Description : Shared types and constants for the lighthouse sweep timer.
// Revision    : 1.0 - initial release
// ============================================================================
package lighthouse_pkg;

    localparam int TS_W = 16;
    localparam logic [TS_W-1:0] NO_HIT = 16'hFFFF;

    localparam int SENS_F = 0;
    localparam int SENS_C = 1;
    localparam int SENS_L = 2;
    localparam int SENS_R = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_SYNC = 2'd1,
        SWEEP     = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sensor_cond.sv
`default_nettype none
// ============================================================================
// Module      : sensor_cond
// Description : Two-flop synchronizer, optional 3-sample deglitch filter
//               (SENSOR_DEGLITCH_EN) and rising-edge detect for one sensor.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_cond (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    // Flops reset high so a line already high at release produces no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SENSOR_DEGLITCH_EN
    logic r_hist1;
    logic r_hist2;
    logic r_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist1 <= 1'b1;
            r_hist2 <= 1'b1;
            r_filt  <= 1'b1;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
            r_filt  <= w_level;
        end
    end

    // The current sample plus two history samples must agree before the level
    // moves, giving the same 2-cycle delay on rising and falling edges.
    assign w_level = ((r_sync2 == r_hist1) && (r_hist1 == r_hist2)) ? r_sync2 : r_filt;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/lighthouse_sweep_timer.sv
`default_nettype none
// ============================================================================
// Module      : lighthouse_sweep_timer
// Description : Timestamps sweep hits on four photodiodes relative to the
//               preceding sync flash. Optional macro: SENSOR_DEGLITCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lighthouse_sweep_timer
    import lighthouse_pkg::*;
#(
    parameter int PRESCALE       = 8,
    parameter int SYNC_MIN_TICKS = 375,
    parameter int TIMEOUT_TICKS  = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      sensor_in,
    output logic [TS_W-1:0] F,
    output logic [TS_W-1:0] C,
    output logic [TS_W-1:0] L,
    output logic [TS_W-1:0] R,
    output logic [3:0]      valid_mask,
    output logic [TS_W-1:0] sync_width,
    output logic            latch,
    output logic            sweeping
);

    localparam int              c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
    localparam logic [TS_W-1:0] c_SYNC_MIN = TS_W'(SYNC_MIN_TICKS);
    localparam logic [TS_W-1:0] c_TIMEOUT  = TS_W'(TIMEOUT_TICKS);

    logic [3:0]         w_level;
    logic [3:0]         w_rise;
    logic               w_any_high;
    logic               r_any_prev;
    logic               w_any_rise;

    state_t             r_state;
    state_t             w_next_state;

    logic [c_PRE_W-1:0] r_pre_cnt;
    logic               w_tick;
    logic [TS_W-1:0]    r_tcnt;
    logic [TS_W-1:0]    w_ts;

    logic               w_frame_start;
    logic               w_sync_fall;
    logic               w_sync_ok;
    logic               w_sweep;
    logic               w_load;
    logic               w_capture_en;

    logic [3:0]         r_hit;
    logic [TS_W-1:0]    r_cap [4];
    logic [TS_W-1:0]    r_sync_hold;
    logic [TS_W-1:0]    r_f;
    logic [TS_W-1:0]    r_c;
    logic [TS_W-1:0]    r_l;
    logic [TS_W-1:0]    r_r;
    logic [3:0]         r_valid_mask;
    logic [TS_W-1:0]    r_sync_width;
    logic               r_latch;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sensor
            sensor_cond u_cond (
                .clk     (clk),
                .rst     (rst),
                .i_raw   (sensor_in[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    assign w_any_high = |w_level;
    assign w_any_rise = w_any_high & ~r_any_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_prev <= 1'b1;
        end else begin
            r_any_prev <= w_any_high;
        end
    end

    assign w_frame_start = (r_state == IDLE) && w_any_rise;
    assign w_tick        = (r_pre_cnt == c_PRE_LAST);

    // w_ts already includes this cycle's tick, so the value seen k clocks
    // after the sync edge is floor(k / PRESCALE).
    assign w_ts = (w_tick && (r_tcnt != NO_HIT)) ? r_tcnt + 1'b1 : r_tcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_tcnt    <= '0;
        end else begin
            if (w_frame_start || w_tick) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
            r_tcnt <= w_frame_start ? '0 : w_ts;
        end
    end

    assign w_sync_fall = (r_state == MEAS_SYNC) && !w_any_high;
    assign w_sync_ok   = w_sync_fall && (w_ts >= c_SYNC_MIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_rise) begin
                    w_next_state = MEAS_SYNC;
                end
            end
            MEAS_SYNC: begin
                if (w_sync_fall) begin
                    w_next_state = w_sync_ok ? SWEEP : IDLE;
                end else if (w_ts >= c_TIMEOUT) begin
                    w_next_state = IDLE;
                end
            end
            SWEEP: begin
                if (w_ts >= c_TIMEOUT) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_sweep      = 1'b0;
        w_load       = 1'b0;
        w_capture_en = 1'b0;
        case (r_state)
            SWEEP: begin
                w_sweep      = 1'b1;
                w_capture_en = 1'b1;
            end
            DONE: begin
                w_load = 1'b1;
            end
            default: begin
                w_sweep = 1'b0;
            end
        endcase
    end

    // Results and the strobe are registered together from DONE, so latch and
    // the new words appear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit        <= '0;
            r_sync_hold  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cap[i] <= '0;
            end
            r_f          <= '0;
            r_c          <= '0;
            r_l          <= '0;
            r_r          <= '0;
            r_valid_mask <= '0;
            r_sync_width <= '0;
            r_latch      <= 1'b0;
        end else begin
            r_latch <= w_load;
            if (w_frame_start) begin
                r_hit <= '0;
            end
            if (w_sync_ok) begin
                r_sync_hold <= w_ts;
            end
            if (w_capture_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_rise[i] && !r_hit[i]) begin
                        r_cap[i] <= w_ts;
                        r_hit[i] <= 1'b1;
                    end
                end
            end
            if (w_load) begin
                r_f          <= r_hit[SENS_F] ? r_cap[SENS_F] : NO_HIT;
                r_c          <= r_hit[SENS_C] ? r_cap[SENS_C] : NO_HIT;
                r_l          <= r_hit[SENS_L] ? r_cap[SENS_L] : NO_HIT;
                r_r          <= r_hit[SENS_R] ? r_cap[SENS_R] : NO_HIT;
                r_valid_mask <= r_hit;
                r_sync_width <= r_sync_hold;
            end
        end
    end

    assign F          = r_f;
    assign C          = r_c;
    assign L          = r_l;
    assign R          = r_r;
    assign valid_mask = r_valid_mask;
    assign sync_width = r_sync_width;
    assign latch      = r_latch;
    assign sweeping   = w_sweep;

endmodule
`default_nettype wire

// File: tb/tb_lighthouse_sweep_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lighthouse_sweep_timer
// Description : Directed and random frames on two timer instances (PRESCALE 1
//               and 3) against an arithmetic model of the timestamp rules.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lighthouse_sweep_timer;

    localparam int P_A = 1, SM_A = 10, TO_A = 200;
    localparam int P_B = 3, SM_B = 4,  TO_B = 66;
    localparam int FRAME_LEN = 230;
`ifdef SENSOR_DEGLITCH_EN
    localparam int DG_LAT = 2, MIN_W = 3, HIT_LEN = 4, S6_C = 80;
`else
    localparam int DG_LAT = 0, MIN_W = 1, HIT_LEN = 1, S6_C = 30;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sensor_in = 4'h0;
    logic [15:0] a_F, a_C, a_L, a_R, a_sw, b_F, b_C, b_L, b_R, b_sw;
    logic [3:0]  a_mask, b_mask;
    logic        a_latch, a_sweeping, b_latch, b_sweeping;

    always #5 clk = ~clk;

    lighthouse_sweep_timer #(.PRESCALE(P_A), .SYNC_MIN_TICKS(SM_A), .TIMEOUT_TICKS(TO_A)) u_dut_a (
        .clk(clk), .rst(rst), .sensor_in(sensor_in),
        .F(a_F), .C(a_C), .L(a_L), .R(a_R), .valid_mask(a_mask),
        .sync_width(a_sw), .latch(a_latch), .sweeping(a_sweeping)
    );

    lighthouse_sweep_timer #(.PRESCALE(P_B), .SYNC_MIN_TICKS(SM_B), .TIMEOUT_TICKS(TO_B)) u_dut_b (
        .clk(clk), .rst(rst), .sensor_in(sensor_in),
        .F(b_F), .C(b_C), .L(b_L), .R(b_R), .valid_mask(b_mask),
        .sync_width(b_sw), .latch(b_latch), .sweeping(b_sweeping)
    );

    int cyc = 0;
    int a_latch_cnt = 0, b_latch_cnt = 0, a_latch_cyc = 0, b_latch_cyc = 0;
    int a_sweep_cnt = 0, b_sweep_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_latch) begin
            a_latch_cnt <= a_latch_cnt + 1;
            a_latch_cyc <= cyc;
        end
        if (b_latch) begin
            b_latch_cnt <= b_latch_cnt + 1;
            b_latch_cyc <= cyc;
        end
        if (a_sweeping) a_sweep_cnt <= a_sweep_cnt + 1;
        if (b_sweeping) b_sweep_cnt <= b_sweep_cnt + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    // Pulse table: start clock and length per sensor, two slots; start < 0 = unused.
    int ps [4][2];
    int pl [4][2];

    logic [3:0][15:0] ea_ts = '0, eb_ts = '0;
    logic [3:0]       ea_mask = '0, eb_mask = '0;
    logic [15:0]      ea_sw = '0, eb_sw = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 2; j++) begin
                ps[i][j] = -1;
                pl[i][j] = 0;
            end
        end
    endtask

    task automatic add_pulse(input int i, input int slot, input int start, input int len);
        ps[i][slot] = start;
        pl[i][slot] = len;
    endtask

    function automatic logic in_pulse(input int i, input int t);
        logic hit = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (ps[i][j] >= 0 && t >= ps[i][j] && t < ps[i][j] + pl[i][j]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Reference: the first visible rising edge inside the window gives floor(k/P).
    function automatic void model(input int p, input int sm, input int to, input int w,
                                  output logic acc, output logic [3:0][15:0] ts,
                                  output logic [3:0] mask, output logic [15:0] sw);
        acc = ((w / p) >= sm);
        sw  = 16'(w / p);
        for (int i = 0; i < 4; i++) begin
            int best = -1;
            for (int j = 0; j < 2; j++) begin
                if (ps[i][j] >= 0 && pl[i][j] >= MIN_W && ps[i][j] <= to * p &&
                    (best < 0 || ps[i][j] < best)) best = ps[i][j];
            end
            mask[i] = (best >= 0);
            ts[i]   = (best >= 0) ? 16'(best / p) : 16'hFFFF;
        end
    endfunction

    task automatic check_set(input string pfx, input logic [3:0][15:0] obs_ts,
                             input logic [3:0] obs_mask, input logic [15:0] obs_sw,
                             input logic [3:0][15:0] e_ts, input logic [3:0] e_mask,
                             input logic [15:0] e_sw);
        chk({pfx, "_F"}, 32'(obs_ts[0]), 32'(e_ts[0]));
        chk({pfx, "_C"}, 32'(obs_ts[1]), 32'(e_ts[1]));
        chk({pfx, "_L"}, 32'(obs_ts[2]), 32'(e_ts[2]));
        chk({pfx, "_R"}, 32'(obs_ts[3]), 32'(e_ts[3]));
        chk({pfx, "_mask"}, 32'(obs_mask), 32'(e_mask));
        chk({pfx, "_sync_width"}, 32'(obs_sw), 32'(e_sw));
    endtask

    task automatic run_frame(input string name, input int w, input int rst_at);
        logic acc_a, acc_b;
        logic [3:0][15:0] ts_a, ts_b;
        logic [3:0] m_a, m_b;
        logic [15:0] sw_a, sw_b;
        logic [3:0] v;
        int a_l0, b_l0, a_s0, b_s0, c0;
        model(P_A, SM_A, TO_A, w, acc_a, ts_a, m_a, sw_a);
        model(P_B, SM_B, TO_B, w, acc_b, ts_b, m_b, sw_b);
        a_l0 = a_latch_cnt; b_l0 = b_latch_cnt;
        a_s0 = a_sweep_cnt; b_s0 = b_sweep_cnt;
        c0 = 0;
        for (int t = 0; t < FRAME_LEN; t++) begin
            @(negedge clk);
            if (t == 0) c0 = cyc;
            for (int i = 0; i < 4; i++) v[i] = (t < w) || in_pulse(i, t);
            sensor_in = v;
            rst = (t == rst_at);
        end
        @(negedge clk);
        rst = 1'b0;
        sensor_in = 4'h0;
        #1;
        if (rst_at >= 0) begin
            acc_a = 1'b0; acc_b = 1'b0;
            ea_ts = '0; ea_mask = '0; ea_sw = '0;
            eb_ts = '0; eb_mask = '0; eb_sw = '0;
        end else begin
            if (acc_a) begin ea_ts = ts_a; ea_mask = m_a; ea_sw = sw_a; end
            if (acc_b) begin eb_ts = ts_b; eb_mask = m_b; eb_sw = sw_b; end
            chk({name, "_A_sweep_cycles"}, 32'(a_sweep_cnt - a_s0), acc_a ? 32'(TO_A * P_A - w) : 32'd0);
            chk({name, "_B_sweep_cycles"}, 32'(b_sweep_cnt - b_s0), acc_b ? 32'(TO_B * P_B - w) : 32'd0);
        end
        chk({name, "_A_latches"}, 32'(a_latch_cnt - a_l0), acc_a ? 32'd1 : 32'd0);
        chk({name, "_B_latches"}, 32'(b_latch_cnt - b_l0), acc_b ? 32'd1 : 32'd0);
        if (acc_a) chk({name, "_A_latch_cycle"}, 32'(a_latch_cyc - c0), 32'(TO_A * P_A + 4 + DG_LAT));
        if (acc_b) chk({name, "_B_latch_cycle"}, 32'(b_latch_cyc - c0), 32'(TO_B * P_B + 4 + DG_LAT));
        check_set({name, "_A"}, {a_R, a_L, a_C, a_F}, a_mask, a_sw, ea_ts, ea_mask, ea_sw);
        check_set({name, "_B"}, {b_R, b_L, b_C, b_F}, b_mask, b_sw, eb_ts, eb_mask, eb_sw);
    endtask

    task automatic setup_s1();
        clear_pulses();
        add_pulse(0, 0, 50,  HIT_LEN);
        add_pulse(1, 0, 80,  HIT_LEN);
        add_pulse(2, 0, 120, HIT_LEN);
        add_pulse(3, 0, 150, HIT_LEN);
    endtask

    initial begin
        int w, s, len;
        rst = 1'b1;
        sensor_in = 4'h0;
        clear_pulses();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_set("reset_A", {a_R, a_L, a_C, a_F}, a_mask, a_sw, '0, 4'h0, 16'h0);
        chk("reset_latch", 32'(a_latch), 32'd0);
        chk("reset_sweeping", 32'(a_sweeping), 32'd0);

        setup_s1();
        run_frame("s1", 20, -1);
        chk("s1_F_const", 32'(a_F), 32'd50);
        chk("s1_R_const", 32'(a_R), 32'd150);
        chk("s1_mask_const", 32'(a_mask), 32'hF);
        chk("s1_sw_const", 32'(a_sw), 32'd20);

        clear_pulses();
        run_frame("s2", 5, -1);

        clear_pulses();
        add_pulse(0, 0, 40, HIT_LEN);
        add_pulse(3, 0, 190, HIT_LEN);
        run_frame("s3", 25, -1);
        chk("s3_C_const", 32'(a_C), 32'hFFFF);

        clear_pulses();
        add_pulse(2, 0, 60, 4);
        add_pulse(2, 1, 90, 4);
        add_pulse(0, 0, 70, 4);
        add_pulse(1, 0, 70, 4);
        run_frame("s4", 20, -1);
        chk("s4_L_const", 32'(a_L), 32'd60);

        setup_s1();
        run_frame("s5_rst", 20, 100);
        setup_s1();
        run_frame("s5_after", 20, -1);
        chk("s5_C_const", 32'(a_C), 32'd80);

        setup_s1();
        add_pulse(1, 1, 30, 2);
        run_frame("s6", 20, -1);
        chk("s6_C_const", 32'(a_C), 32'(S6_C));

        for (int f = 0; f < 8; f++) begin
            clear_pulses();
            w = int'($urandom_range(4, 30));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    s   = int'($urandom_range(w + 3, 190));
                    len = int'($urandom_range(3, 6));
                    add_pulse(i, 0, s, len);
                    s = s + len + 3 + int'($urandom_range(0, 20));
                    if ($urandom_range(0, 1) == 1 && s <= 203) add_pulse(i, 1, s, int'($urandom_range(3, 6)));
                end
            end
            run_frame("rand", w, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
